seq_gen: RTL and testbench

Serial stimulus transmitter driving the three-state sequence detector's `In1` input. It loads a pattern word and shifts it out one bit per clock, LSB first, with a programmable repeat count and a one-cycle idle gap between repeats. A Start/Busy/Done handshake connects it to the controlling logic. An optional built-in model of the detector produces the expected detector output alongside each transmitted bit, for self-checking.

---
 rtl/seq_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_seq_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial stimulus transmitter for the three-state sequence detector
//
// Loads a pattern word and shifts it out LSB first, one bit per clock, with
// a programmable repeat count and a single idle gap cycle between repeats.
// Start/Busy/Done handshake toward the controlling logic.
//
// Optional feature macro: SEQ_GEN_MODEL_EN
//   defined   - a built-in model of the detector drives Expect
//   undefined - no model logic, Expect tied to 0
//
// Parameters:
//   WIDTH   maximum pattern length in bits (>= 2)
//   CNT_W   repeat-count width
//
// Ports:
//   CLK      clock, rising edge
//   RST_N    synchronous active-low reset
//   Start    transmission request, honoured only in IDLE
//   Pattern  bits to send, bit 0 first
//   Len      number of bits to send (1..WIDTH, larger values clamp to WIDTH)
//   Repeat   extra repetitions, total transmissions = Repeat + 1
//   Out1     registered serial bit
//   Valid    Out1 carries a pattern bit this cycle
//   Busy     transmission in progress (SEND, GAP, DONE)
//   Done     one-cycle completion pulse
//   Expect   expected detector output, lags the matching Out1 bit by one cycle

module seq_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       Start,
    input  logic [WIDTH-1:0]           Pattern,
    input  logic [$clog2(WIDTH+1)-1:0] Len,
    input  logic [CNT_W-1:0]           Repeat,
    output logic                       Out1,
    output logic                       Valid,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Expect
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q,   pat_d;
    logic [LW-1:0]    len_q,   len_d;
    logic [CNT_W-1:0] rep_q,   rep_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic             out1_q,  out1_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             start_acc;
    logic             last_bit;
    logic [IW-1:0]    idx_inc;

    // idx_q is the index of the bit currently on Out1, so the bit shown
    // this cycle is the last one when idx_q + 1 equals the captured length.
    assign idx_inc  = idx_q + IW'(1);
    assign last_bit = ((LW'(idx_q) + LW'(1)) == len_q);

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        rep_d     = rep_q;
        idx_d     = idx_q;
        out1_d    = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        start_acc = 1'b0;

        // Outputs are computed for the state being entered so that they
        // appear registered in the very cycle that state is occupied.
        case (state_q)
            ST_IDLE: begin
                if (Start && (Len != '0)) begin
                    start_acc = 1'b1;
                    pat_d     = Pattern;
                    len_d     = (Len > LW'(WIDTH)) ? LW'(WIDTH) : Len;
                    rep_d     = Repeat;
                    idx_d     = '0;
                    out1_d    = Pattern[0];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                if (last_bit) begin
                    // Test for zero before decrementing so rep_q never wraps.
                    if (rep_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rep_d   = rep_q - CNT_W'(1);
                        state_d = ST_GAP;
                    end
                end else begin
                    idx_d   = idx_inc;
                    out1_d  = pat_q[idx_inc];
                    valid_d = 1'b1;
                end
            end
            ST_GAP: begin
                busy_d  = 1'b1;
                idx_d   = '0;
                out1_d  = pat_q[0];
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            out1_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            out1_q  <= out1_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Out1  = out1_q;
    assign Valid = valid_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

`ifdef SEQ_GEN_MODEL_EN
    typedef enum logic [1:0] {
        M_A = 2'd0,
        M_B = 2'd1,
        M_C = 2'd2
    } model_t;

    model_t model_q,  model_d;
    logic   expect_q, expect_d;

    // The model watches the registered serial line, so Expect trails the
    // bit it reacts to by one cycle just like the real detector's output.
    always_comb begin
        model_d  = model_q;
        expect_d = expect_q;
        if (start_acc) begin
            model_d  = M_A;
            expect_d = 1'b0;
        end else if (valid_q) begin
            case (model_q)
                M_A: begin
                    if (out1_q) begin
                        model_d  = M_B;
                        expect_d = 1'b0;
                    end
                end
                M_B: begin
                    if (!out1_q) begin
                        model_d  = M_C;
                        expect_d = 1'b1;
                    end
                end
                M_C: begin
                    if (out1_q) begin
                        model_d  = M_A;
                        expect_d = 1'b0;
                    end
                end
                default: begin
                    model_d  = M_A;
                    expect_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            model_q  <= M_A;
            expect_q <= 1'b0;
        end else begin
            model_q  <= model_d;
            expect_q <= expect_d;
        end
    end

    assign Expect = expect_q;
`else
    assign Expect = 1'b0;
`endif

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - self-checking bench for seq_gen

module tb_seq_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic       out1, valid, busy, done, xpct;

    int n_vec  = 0;
    int n_miss = 0;

    seq_gen #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .Start   (start),
        .Pattern (pattern),
        .Len     (len),
        .Repeat  (rep),
        .Out1    (out1),
        .Valid   (valid),
        .Busy    (busy),
        .Done    (done),
        .Expect  (xpct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  len;
        logic [3:0]  rep;
        logic [31:0] exp_out;
        logic [31:0] exp_valid;
        int          cycles;
    } vec_t;

    typedef struct packed {
        logic out1;
        logic valid;
        logic busy;
        logic done;
        logic xp;
    } rec_t;

    vec_t vecs[6];
    rec_t sb[$];
    string sb_tag = "";

    // Reference detector state: 0=A, 1=B, 2=C.
    int   m_state = 0;
    logic m_exp   = 1'b0;

    function automatic logic model_exp();
`ifdef SEQ_GEN_MODEL_EN
        return m_exp;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_step(input logic b);
        case (m_state)
            0: if (b)  begin m_state = 1; m_exp = 1'b0; end
            1: if (!b) begin m_state = 2; m_exp = 1'b1; end
            2: if (b)  begin m_state = 0; m_exp = 1'b0; end
            default: begin m_state = 0; m_exp = 1'b0; end
        endcase
    endfunction

    function automatic void push_vec(input int i);
        rec_t r;
        if (vecs[i].cycles == 0) begin
            for (int k = 0; k < 3; k++) begin
                r = '{out1: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, xp: model_exp()};
                sb.push_back(r);
            end
            return;
        end
        m_state = 0;
        m_exp   = 1'b0;
        for (int c = 0; c < vecs[i].cycles; c++) begin
            r.out1  = vecs[i].exp_out[c];
            r.valid = vecs[i].exp_valid[c];
            r.busy  = 1'b1;
            r.done  = (c == vecs[i].cycles - 1);
            r.xp    = model_exp();
            sb.push_back(r);
            if (r.valid) model_step(r.out1);
        end
        r = '{out1: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, xp: model_exp()};
        sb.push_back(r);
    endfunction

    always @(negedge clk) begin
        rec_t r;
        rec_t got;
        if (sb.size() > 0) begin
            r   = sb.pop_front();
            got = '{out1: out1, valid: valid, busy: busy, done: done, xp: xpct};
            n_vec++;
            if (got !== r)begin
                n_miss++;
                $display("FAIL sb_%0s got {out1,valid,busy,done,expect}=%b exp=%b", sb_tag, got, r);
            end
        end
    end

    task automatic check_idle(input string name);
        logic [4:0] got;
        got = {out1, valid, busy, done, xpct};
        n_vec++;
        if (got !== 5'b0) begin
            n_miss++;
            $display("FAIL %0s outputs=%b exp=00000", name, got);
        end
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 200 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL %0s_timeout pending=%0d exp=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic drive_start(input int i);
        @(posedge clk);
        #1;
        pattern = vecs[i].pattern;
        len     = vecs[i].len;
        rep     = vecs[i].rep;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic run_vec(input int i);
        sb_tag = $sformatf("vec%0d", i);
        drive_start(i);
        push_vec(i);
        wait_empty(sb_tag);
    endtask

    initial begin
        vecs[0] = '{8'h05, 4'd3,  4'd0, 32'h0000_0005, 32'h0000_0007, 4};
        vecs[1] = '{8'h02, 4'd2,  4'd2, 32'h0000_0092, 32'h0000_00DB, 9};
        vecs[2] = '{8'hA5, 4'd15, 4'd0, 32'h0000_00A5, 32'h0000_00FF, 9};
        vecs[3] = '{8'hFF, 4'd1,  4'd3, 32'h0000_0055, 32'h0000_0055, 8};
        vecs[4] = '{8'h81, 4'd8,  4'd1, 32'h0001_0281, 32'h0001_FEFF, 18};
        vecs[5] = '{8'hFF, 4'd0,  4'd2, 32'h0000_0000, 32'h0000_0000, 0};

        rst_n   = 1'b0;
        start   = 1'b1;
        pattern = 8'h05;
        len     = 4'd3;
        rep     = 4'd0;

        // Reset held with Start asserted: everything stays quiet.
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("after_reset");
        end

        for (int i = 0; i < 6; i++) run_vec(i);

        // Start pulses during SEND and during the DONE cycle are ignored.
        sb_tag = "busy_start";
        drive_start(0);
        push_vec(0);
        pattern = 8'hFF;
        len     = 4'd8;
        rep     = 4'd3;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_empty("busy_start");

        // Reset during the second bit aborts without Done.
        drive_start(1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_state = 0;
        m_exp   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_idle("mid_reset");
        end
        run_vec(0);
        run_vec(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
